// File: rtl/secded_dec_seq.sv
// -----------------------------------------------------------------------------
// secded_dec_seq
//
// Purpose:
//   Sequencer for the Hamming SECDED decode task. It runs as a second master on
//   the single-port data memory. For each of NUM_MSG 16-bit codewords, read as
//   two bytes from SRC_BASE+2i, it checks the syndrome, corrects a single-bit
//   error, flags a double-bit error and writes the 16-bit result back as two
//   bytes at DST_BASE+2i. Each reset pulse starts one run. The first clock edge
//   with reset low starts the sequence.
//
// Optional feature:
//   Define the macro SECDED_STATS_EN to get saturating counters for codewords
//   with a single error and with a double error. When the macro is undefined,
//   the design has no counter flops and both count ports read 0.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset; also the start request
//   o_dm_addr      data memory byte address (AW bits)
//   i_dm_rd_data   data memory read data; combinational read of o_dm_addr
//   o_dm_wr_en     write strobe; the byte is written at the rising edge
//   o_dm_wr_data   write data
//   o_busy         high while the sequence is running
//   o_done         high from completion until the next reset
//   o_err1_cnt     count of single-error codewords (0 without SECDED_STATS_EN)
//   o_err2_cnt     count of double-error codewords (0 without SECDED_STATS_EN)
// -----------------------------------------------------------------------------
module secded_dec_seq #(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 30,
    parameter int DST_BASE = 0,
    parameter int AW       = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    output logic [AW-1:0] o_dm_addr,
    input  logic [7:0]    i_dm_rd_data,
    output logic          o_dm_wr_en,
    output logic [7:0]    o_dm_wr_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [4:0]    o_err1_cnt,
    output logic [4:0]    o_err2_cnt
);

    localparam int IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_LO  = 3'd1,
        S_RD_HI  = 3'd2,
        S_DECODE = 3'd3,
        S_WR_LO  = 3'd4,
        S_WR_HI  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    // Returns the byte address base + 2*idx + hi.
    function automatic logic [AW-1:0] f_addr(input int base,
                                             input logic [IW-1:0] idx,
                                             input logic hi);
        f_addr = AW'(base) + AW'({idx, hi});
    endfunction

    // SECDED decode of one codeword. The result holds {flags[1:0], 3'b0, d[11:1]}.
    // flags: 01 = single error corrected, 10 = double error with raw data.
    function automatic logic [15:0] f_secded(input logic [15:0] c);
        logic [3:0]  s;
        logic        p;
        logic [15:0] cc;
        logic [10:0] d_fix;
        logic [10:0] d_raw;
        s = 4'd0;
        for (int k = 1; k < 16; k++) begin
            s = s ^ ({4{c[k]}} & 4'(k));
        end
        p  = ^c;
        cc = c;
        // With odd overall parity, exactly one bit flipped; s == 0 points at p0.
        if (p) begin
            cc[s] = ~cc[s];
        end else begin
            cc = c;
        end
        d_fix = {cc[15:9], cc[7:5], cc[3]};
        d_raw = {c[15:9], c[7:5], c[3]};
        if (p) begin
            f_secded = {2'b01, 3'b000, d_fix};
        end else if (s != 4'd0) begin
            f_secded = {2'b10, 3'b000, d_raw};
        end else begin
            f_secded = {2'b00, 3'b000, d_raw};
        end
    endfunction

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [7:0]      r_lo;
    logic [7:0]      r_hi;
    logic [7:0]      r_res_hi;
    logic [AW-1:0]   r_addr;
    logic            r_wr_en;
    logic [7:0]      r_wr_data;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     w_result;

    assign w_result = f_secded({r_hi, r_lo});

    // Main sequencer: state, memory port and status outputs are all registered.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_lo      <= 8'd0;
            r_hi      <= 8'd0;
            r_res_hi  <= 8'd0;
            r_addr    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_data <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_RD_LO;
                    r_idx   <= '0;
                    r_addr  <= f_addr(SRC_BASE, '0, 1'b0);
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b1;
                end
                S_RD_LO: begin
                    r_lo    <= i_dm_rd_data;
                    r_addr  <= f_addr(SRC_BASE, r_idx, 1'b1);
                    r_state <= S_RD_HI;
                end
                S_RD_HI: begin
                    r_hi    <= i_dm_rd_data;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_res_hi  <= w_result[15:8];
                    r_addr    <= f_addr(DST_BASE, r_idx, 1'b0);
                    r_wr_en   <= 1'b1;
                    r_wr_data <= w_result[7:0];
                    r_state   <= S_WR_LO;
                end
                S_WR_LO: begin
                    r_addr    <= f_addr(DST_BASE, r_idx, 1'b1);
                    r_wr_en   <= 1'b1;
                    r_wr_data <= r_res_hi;
                    r_state   <= S_WR_HI;
                end
                S_WR_HI: begin
                    r_wr_en <= 1'b0;
                    if (r_idx == IW'(NUM_MSG - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                        r_addr  <= f_addr(SRC_BASE, r_idx + IW'(1), 1'b0);
                        r_state <= S_RD_LO;
                    end
                end
                S_DONE: begin
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wr_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_dm_addr    = r_addr;
    assign o_dm_wr_en   = r_wr_en;
    assign o_dm_wr_data = r_wr_data;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

`ifdef SECDED_STATS_EN
    logic [4:0] r_err1_cnt;
    logic [4:0] r_err2_cnt;

    // Error statistics: counted once per codeword in DECODE, saturating at 31.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_err1_cnt <= 5'd0;
            r_err2_cnt <= 5'd0;
        end else if (r_state == S_DECODE) begin
            if (w_result[14] && (r_err1_cnt != 5'd31)) begin
                r_err1_cnt <= r_err1_cnt + 5'd1;
            end else begin
                r_err1_cnt <= r_err1_cnt;
            end
            if (w_result[15] && (r_err2_cnt != 5'd31)) begin
                r_err2_cnt <= r_err2_cnt + 5'd1;
            end else begin
                r_err2_cnt <= r_err2_cnt;
            end
        end else begin
            r_err1_cnt <= r_err1_cnt;
            r_err2_cnt <= r_err2_cnt;
        end
    end

    assign o_err1_cnt = r_err1_cnt;
    assign o_err2_cnt = r_err2_cnt;
`else
    assign o_err1_cnt = 5'd0;
    assign o_err2_cnt = 5'd0;
`endif

endmodule

// File: tb/tb_secded_dec_seq.sv
// -----------------------------------------------------------------------------
// tb_secded_dec_seq
//
// Bench for secded_dec_seq. It models a data memory with combinational read.
// Stimulus preloads 15 hand-encoded codewords and pushes the expected write
// stream (address and byte) into a queue. A monitor on the falling clock edge
// pops one entry and compares it for every cycle in which the DUT drives a
// write. The bench runs a full decode run, then a run that is aborted by reset
// during message 7, followed by a complete rerun.
// -----------------------------------------------------------------------------
module tb_secded_dec_seq;

    logic       clk;
    logic       reset;
    logic [7:0] dm_addr;
    logic [7:0] dm_rd_data;
    logic       dm_wr_en;
    logic [7:0] dm_wr_data;
    logic       busy;
    logic       done;
    logic [4:0] err1_cnt;
    logic [4:0] err2_cnt;

    logic [7:0] mem [0:255];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Hand-encoded codewords and their hand-decoded 16-bit results.
    logic [15:0] cw_tab [0:14] = '{
        16'h000F, 16'h0007, 16'h000E, 16'h0027, 16'h0000,
        16'hFFFF, 16'h7FFF, 16'hFFF9, 16'h8117, 16'h8317,
        16'h8017, 16'h0A5F, 16'h005F, 16'h0A1F, 16'h0A56
    };
    logic [15:0] res_tab [0:14] = '{
        16'h0001, 16'h4001, 16'h4001, 16'h8002, 16'h0000,
        16'h07FF, 16'h47FF, 16'h87FF, 16'h0400, 16'h4400,
        16'h4400, 16'h0055, 16'h8005, 16'h4055, 16'h8054
    };

    secded_dec_seq dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .o_dm_addr    (dm_addr),
        .i_dm_rd_data (dm_rd_data),
        .o_dm_wr_en   (dm_wr_en),
        .o_dm_wr_data (dm_wr_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_err1_cnt   (err1_cnt),
        .o_err2_cnt   (err2_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rd_data = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_wr_en) begin
            mem[dm_addr] <= dm_wr_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each write the DUT presents must match the next expected write.
    always @(negedge clk) begin
        if (dm_wr_en !== 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                         dm_addr, dm_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, dm_addr}, {24'd0, e.addr});
                chk("wr_data", {24'd0, dm_wr_data}, {24'd0, e.data});
            end
        end
    end

    task automatic push_expected();
        for (int i = 0; i < 15; i++) begin
            wr_t e;
            e.addr = 8'(2 * i);
            e.data = res_tab[i][7:0];
            exp_q.push_back(e);
            e.addr = 8'(2 * i + 1);
            e.data = res_tab[i][15:8];
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_dst();
        for (int a = 0; a < 30; a++) begin
            mem[a] = 8'hEE;
        end
    endtask

    // Releases reset and waits (bounded) for done; checks completion timing.
    task automatic run_full(input string tag);
        int k;
        push_expected();
        @(posedge clk);
        #2 reset = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) begin
                chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
                chk({tag, "_addr_start"}, {24'd0, dm_addr}, 32'd30);
            end
        end
        chk({tag, "_done_edge"}, k, 32'd76);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_hold"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_wr_en_end"}, {31'd0, dm_wr_en}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk({tag, "_mem_result"}, {16'd0, mem[2*i+1], mem[2*i]}, {16'd0, res_tab[i]});
        end
`ifdef SECDED_STATS_EN
        chk({tag, "_err1_cnt"}, {27'd0, err1_cnt}, 32'd6);
        chk({tag, "_err2_cnt"}, {27'd0, err2_cnt}, 32'd4);
`else
        chk({tag, "_err1_cnt"}, {27'd0, err1_cnt}, 32'd0);
        chk({tag, "_err2_cnt"}, {27'd0, err2_cnt}, 32'd0);
`endif
    endtask

    initial begin
        int k;
        reset = 1'b1;
        for (int a = 0; a < 256; a++) begin
            mem[a] = 8'h00;
        end
        for (int i = 0; i < 15; i++) begin
            mem[30 + 2*i]     = cw_tab[i][7:0];
            mem[30 + 2*i + 1] = cw_tab[i][15:8];
        end
        clear_dst();

        repeat (3) @(posedge clk);
        #2;
        chk("rst_addr",    {24'd0, dm_addr}, 32'd0);
        chk("rst_wr_en",   {31'd0, dm_wr_en}, 32'd0);
        chk("rst_wr_data", {24'd0, dm_wr_data}, 32'd0);
        chk("rst_busy",    {31'd0, busy}, 32'd0);
        chk("rst_done",    {31'd0, done}, 32'd0);
        chk("rst_err1",    {27'd0, err1_cnt}, 32'd0);
        chk("rst_err2",    {27'd0, err2_cnt}, 32'd0);

        run_full("run1");

        // Reset from DONE clears done at the first edge.
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_clears_done", {31'd0, done}, 32'd0);
        chk("rst_clears_err1", {27'd0, err1_cnt}, 32'd0);
        clear_dst();

        // Abort during message 7: reset is sampled at the edge ending cycle 37.
        push_expected();
        @(posedge clk);
        #2 reset = 1'b0;
        k = 0;
        while (k < 38) begin
            @(posedge clk);
            #1;
            k++;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_wr_en",  {31'd0, dm_wr_en}, 32'd0);
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_pending", exp_q.size(), 32'd16);
        chk("abort_kept_byte", {24'd0, mem[13]}, {24'd0, res_tab[6][15:8]});
        chk("abort_no_msg7",   {24'd0, mem[14]}, 32'hEE);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("abort_idle_wr_en", {31'd0, dm_wr_en}, 32'd0);

        run_full("rerun");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/secded_dec_seq.md
Name: secded_dec_seq

Overview:
- Hardware sequencer for the program-2 Hamming SECDED decode task.
- Walks NUM_MSG 16-bit codewords in data memory, each stored as two bytes.
- Per codeword: checks the syndrome, corrects single-bit errors, flags double-bit errors, and writes the 16-bit result back as two bytes.
- Sits beside the processor core as a second master on the single-port data memory; top level muxes the memory port to this block while it is busy.

Parameters:
- NUM_MSG, 15, number of codewords processed per run.
- SRC_BASE, 30, byte address of the low byte of codeword 0; high byte at +1; codeword i at SRC_BASE+2i.
- DST_BASE, 0, byte address of the low byte of result 0; high byte at +1; result i at DST_BASE+2i.
- AW, 8, data memory address width.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset; also serves as the start request.
- dm_addr, output, AW, data memory byte address.
- dm_rd_data, input, 8, data memory read data; combinational read of dm_addr, valid the same cycle.
- dm_wr_en, output, 1, write strobe; the byte is written at the rising edge.
- dm_wr_data, output, 8, write data.
- busy, output, 1, high while the sequence is running.
- done, output, 1, high from sequence completion until the next reset.
- err1_cnt, output, 5, count of single-error codewords (see Optional Feature).
- err2_cnt, output, 5, count of double-error codewords (see Optional Feature).

Behaviour:
- Interface (decided): one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values while reset=1: state=IDLE, index=0, dm_addr=0, dm_wr_en=0, dm_wr_data=0, busy=0, done=0, both counters 0.
- Start: the first clock edge with reset=0 moves IDLE->RD_LO. There is no separate start port; each reset pulse is one run.
- FSM per codeword, 5 cycles:
  - RD_LO: addr=SRC_BASE+2i; latch lo byte.
  - RD_HI: addr=SRC_BASE+2i+1; latch hi byte.
  - DECODE: register syndrome and result.
  - WR_LO: addr=DST_BASE+2i, wr_en=1, data=result[7:0].
  - WR_HI: addr=DST_BASE+2i+1, wr_en=1, data=result[15:8].
  - After WR_HI: i==NUM_MSG-1 -> DONE; otherwise i++ and go to RD_LO.
- DONE: busy=0, done=1, wr_en=0. Holds until reset.
- Latency: codeword i occupies cycles 5i..5i+4 after reset release. done=1 from cycle 5*NUM_MSG (75 by default).
- busy=1 in every state except IDLE and DONE.
- Codeword layout c[15:0]:
  - c[15:9]=d[11:5], c[8]=p8, c[7:5]=d[4:2], c[4]=p4, c[3]=d[1], c[2]=p2, c[1]=p1, c[0]=p0.
- Decode:
  - s[3:0] = XOR of positions k (1..15) where c[k]=1.
  - P = XOR of c[15:0].
  - P=0, s=0: no error. result={2'b00,3'b000,d}.
  - P=1: single error. Flip c[s] (s=0 means p0 was flipped, data unchanged). result={2'b01,3'b000,corrected d}.
  - P=0, s!=0: double error. result={2'b10,3'b000,raw d}, no correction.
- Reset during a run: the run aborts at that edge. No further writes; bytes already written stay. Restart from codeword 0 on release.
- wr_en is never asserted outside WR_LO/WR_HI. Source and destination ranges are assumed non-overlapping; overlap gives undefined results.

Optional Feature:
- Macro: SECDED_STATS_EN.
- Defined: err1_cnt increments in DECODE on a single-error codeword; err2_cnt increments in DECODE on a double-error codeword. Both saturate at 31 and clear on reset.
- Undefined: no counter flops; both ports tied to 0.

Test Plan:
- Clean codeword: lo=0x0F, hi=0x00 at 30/31 (d=0x001) -> bytes 0/1 = 0x01/0x00 (result 0x0001); done=1 at cycle 75.
- Single data-bit error: codeword 0x0007 (bit 3 flipped) -> result 0x4001. With SECDED_STATS_EN, err1_cnt=1.
- p0-only error: codeword 0x000E -> result 0x4001, data unchanged.
- Double error: codeword 0x0027 (bits 3 and 5 flipped) -> result 0x8002, MSB=1. With the macro, err2_cnt=1.
- Full run: 15 random codewords, each with 0/1/2 flips -> all 30 output bytes match the reference model, no writes outside addresses 0..29, done holds high.
- Reset mid-run: assert reset during message 7 -> done=0 and wr_en=0 immediately. After release, the full sequence reruns and all results are correct at cycle 75.
